// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding, port constants and port-select helper for the router
package router_pkg;

    localparam int         PORT_COUNT   = 3;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t LOAD_FIRST_DATA    = 3'd1;
    localparam state_t LOAD_DATA          = 3'd2;
    localparam state_t LOAD_PARITY        = 3'd3;
    localparam state_t CHECK_PARITY_ERROR = 3'd4;
    localparam state_t FIFO_FULL_STATE    = 3'd5;
    localparam state_t LOAD_AFTER_FULL    = 3'd6;
    localparam state_t WAIT_TILL_EMPTY    = 3'd7;

    // Pick one per-port flag by address; the invalid address selects nothing.
    function automatic logic port_bit(input logic [PORT_COUNT-1:0] vec, input logic [1:0] addr);
        logic bit_sel;
        case (addr)
            2'd0:    bit_sel = vec[0];
            2'd1:    bit_sel = vec[1];
            2'd2:    bit_sel = vec[2];
            default: bit_sel = 1'b0;
        endcase
        return bit_sel;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - status inputs and phase strobes of the router packet sequencer
interface router_fsm_if;
    import router_pkg::*;

    // source and FIFO/register status
    logic                  pkt_valid;
    logic [1:0]            data_in;
    logic                  fifo_full;
    logic [PORT_COUNT-1:0] fifo_empty;
    logic [PORT_COUNT-1:0] soft_reset;
    logic                  parity_done;
    logic                  low_pkt_valid;

    // phase strobes back to the datapath and source
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic                  write_enb_reg;
    logic                  busy;

    // Side that supplies status and consumes strobes.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );

    // The sequencer itself.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - Moore sequencer for header, payload, parity and FIFO-full phases of the 1x3 router
module router_fsm
    import router_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    logic hdr_ok;
    logic sel_soft_reset;

    // A header is only accepted for one of the three real ports.
    assign hdr_ok         = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
    // Only the timeout of the port we are routing to matters.
    assign sel_soft_reset = port_bit(bus.soft_reset, addr_q);

    // State and latched destination address, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state and address capture; a soft reset outside DA overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        if ((state_q == DECODE_ADDRESS) && hdr_ok) begin
            addr_d = bus.data_in;
        end

        if ((state_q != DECODE_ADDRESS) && sel_soft_reset) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok) begin
                        state_d = port_bit(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                                        : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: begin
                    state_d = LOAD_DATA;
                end
                LOAD_DATA: begin
                    // A full FIFO must be serviced before the packet end is recognised.
                    if (bus.fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!bus.pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    // parity_done means the held byte was the parity: packet complete.
                    if (bus.parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (bus.low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    state_d = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (port_bit(bus.fifo_empty, addr_q)) begin
                        state_d = LOAD_FIRST_DATA;
                    end
                end
                default: begin
                    state_d = DECODE_ADDRESS;
                end
            endcase
        end
    end

    // Strobes decoded from the registered state only.
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                bus.lfd_state = 1'b1;
                bus.busy      = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                bus.busy = 1'b1;
            end
            default: begin
                bus.detect_add = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - scoreboard bench for the router packet sequencer
module tb_router_fsm;

    // Output vector order: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] E_DA  = 8'h80;
    localparam logic [7:0] E_LFD = 8'h41;
    localparam logic [7:0] E_LD  = 8'h22;
    localparam logic [7:0] E_LP  = 8'h03;
    localparam logic [7:0] E_CPE = 8'h05;
    localparam logic [7:0] E_FFS = 8'h09;
    localparam logic [7:0] E_LAF = 8'h13;
    localparam logic [7:0] E_WTE = 8'h01;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    router_fsm_if bus();

    router_fsm dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    function automatic logic [7:0] outs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs due after the next rise.
    task automatic step(input string nm, input logic pv, input logic [1:0] din, input logic ff,
                        input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                        input logic lpv, input logic [7:0] exp);
        @(negedge clk);
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.fifo_full     = ff;
        bus.fifo_empty    = fe;
        bus.soft_reset    = sr;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the settled outputs after each rising edge against the oldest expectation.
    always @(posedge clk) begin
        logic [7:0] e;
        string      n;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, outs(), e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn            = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 3'b111;
        bus.soft_reset    = 3'b000;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;

        #1;
        check("rst_async", outs(), E_DA);
        step("rst_hold0", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_DA);
        step("rst_hold1", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_DA);
        @(negedge clk);
        resetn        = 1'b1;
        bus.pkt_valid = 1'b0;

        // Basic packet to port 1 with two payload bytes
        step("t1_lfd", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t1_ld1", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t1_ld2", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t1_lp",  0, 1, 0, 3'b111, 3'b000, 0, 0, E_LP);
        step("t1_cpe", 0, 0, 0, 3'b111, 3'b000, 0, 0, E_CPE);
        step("t1_da",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_DA);

        // Port 2 busy: wait until its FIFO drains, then a full episode ending via low_pkt_valid
        step("t2_wte", 1, 2, 0, 3'b011, 3'b000, 0, 0, E_WTE);
        for (int i = 0; i < 5; i++) begin
            step("t2_wte_hold", 0, 0, 0, 3'b011, 3'b000, 0, 0, E_WTE);
        end
        step("t2_lfd",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t2_ld",   1, 0, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t2_ffs1", 1, 0, 1, 3'b111, 3'b000, 0, 0, E_FFS);
        step("t2_ffs2", 1, 0, 1, 3'b111, 3'b000, 0, 0, E_FFS);
        step("t2_ffs3", 1, 0, 1, 3'b111, 3'b000, 0, 0, E_FFS);
        step("t2_laf",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_LAF);
        step("t2_lp",   0, 0, 0, 3'b111, 3'b000, 0, 1, E_LP);
        step("t2_cpe",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_CPE);
        step("t2_da",   0, 0, 0, 3'b111, 3'b000, 0, 0, E_DA);

        // Full wins over packet end in LD; parity_done wins over low_pkt_valid in LAF
        step("t3_lfd", 1, 2, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t3_ld",  1, 0, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t3_ffs", 0, 0, 1, 3'b111, 3'b000, 0, 0, E_FFS);
        step("t3_laf", 0, 0, 0, 3'b111, 3'b000, 0, 0, E_LAF);
        step("t3_da",  0, 0, 0, 3'b111, 3'b000, 1, 1, E_DA);

        // Full during parity check, then LAF back to LD
        step("t4_lfd",  1, 0, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t4_ld",   1, 0, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t4_lp",   0, 0, 0, 3'b111, 3'b000, 0, 0, E_LP);
        step("t4_cpe",  0, 0, 1, 3'b111, 3'b000, 0, 0, E_CPE);
        step("t4_ffs",  0, 0, 1, 3'b111, 3'b000, 0, 0, E_FFS);
        step("t4_laf",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_LAF);
        step("t4_ld2",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t4_lp2",  0, 0, 0, 3'b111, 3'b000, 0, 0, E_LP);
        step("t4_cpe2", 0, 0, 0, 3'b111, 3'b000, 0, 0, E_CPE);
        step("t4_da",   0, 0, 0, 3'b111, 3'b000, 0, 0, E_DA);

        // Invalid header: stay in DA, address keeps port 0
        step("t5_inv",  1, 3, 0, 3'b111, 3'b000, 0, 0, E_DA);
        @(posedge clk);
        #2;
        check("t5_addr", {6'd0, dut.addr_q}, 8'd0);
        step("t5_inv2", 1, 3, 0, 3'b000, 3'b000, 0, 0, E_DA);

        // Soft reset while waiting on port 0: other ports ignored, own port aborts
        step("t6_wte",    1, 0, 0, 3'b110, 3'b000, 0, 0, E_WTE);
        step("t6_sr_oth", 0, 0, 0, 3'b110, 3'b010, 0, 0, E_WTE);
        step("t6_sr_own", 0, 0, 0, 3'b110, 3'b001, 0, 0, E_DA);
        step("t6_sr_da",  0, 0, 0, 3'b110, 3'b001, 0, 0, E_DA);
        step("t6_lfd",    1, 2, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t6_sr_lfd", 1, 2, 0, 3'b111, 3'b100, 0, 0, E_DA);
        @(posedge clk);
        #2;
        check("t6_addr", {6'd0, dut.addr_q}, 8'd2);

        // Asynchronous reset in the middle of LD
        step("t7_lfd", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t7_ld",  1, 1, 0, 3'b111, 3'b000, 0, 0, E_LD);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_async_rst", outs(), E_DA);
        check("t7_addr_rst", {6'd0, dut.addr_q}, 8'd0);
        step("t7_hold", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_DA);
        @(negedge clk);
        resetn        = 1'b1;
        bus.pkt_valid = 1'b0;
        step("t7_lfd2", 1, 1, 0, 3'b111, 3'b000, 0, 0, E_LFD);
        step("t7_ld2",  0, 1, 0, 3'b111, 3'b000, 0, 0, E_LD);
        step("t7_lp2",  0, 1, 0, 3'b111, 3'b000, 0, 0, E_LP);
        step("t7_cpe2", 0, 1, 0, 3'b111, 3'b000, 0, 0, E_CPE);
        step("t7_da2",  0, 1, 0, 3'b111, 3'b000, 0, 0, E_DA);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
